// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared widths and the FSM state encoding for the instruction cache.
//   REG_DAT_W    : fetch / memory address width
//   INS_DAT_W    : instruction word width
//   ICACHE_IDX_W : default index width (2^IDX lines of one word each)
//   state_e      : cache controller states (IDLE=0, FILL=1)
// -----------------------------------------------------------------------------
package icache_pkg;

  localparam int REG_DAT_W    = 32;
  localparam int INS_DAT_W    = 32;
  localparam int ICACHE_IDX_W = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/icache_if.sv
// -----------------------------------------------------------------------------
// icache_if
// Bundles the fetch-side, memory-controller-side and ROB flush signals of the
// instruction cache.
//   iIF_En / iIF_Pc     : fetch request strobe and address
//   oIF_En / oIF_Ins    : response strobe and instruction
//   oMC_En / oMC_Addr   : memory read request (held until acknowledged)
//   iMC_En / iMC_Dat    : memory read completion pulse and data
//   iROB_Mp             : misprediction flush
// Modports: slave = cache side, master = fetch/memory/ROB environment side.
// -----------------------------------------------------------------------------
interface icache_if;
  import icache_pkg::*;

  logic                 iIF_En;
  logic [REG_DAT_W-1:0] iIF_Pc;
  logic                 oIF_En;
  logic [INS_DAT_W-1:0] oIF_Ins;
  logic                 oMC_En;
  logic [REG_DAT_W-1:0] oMC_Addr;
  logic                 iMC_En;
  logic [INS_DAT_W-1:0] iMC_Dat;
  logic                 iROB_Mp;

  modport slave (
    input  iIF_En, iIF_Pc, iMC_En, iMC_Dat, iROB_Mp,
    output oIF_En, oIF_Ins, oMC_En, oMC_Addr
  );

  modport master (
    output iIF_En, iIF_Pc, iMC_En, iMC_Dat, iROB_Mp,
    input  oIF_En, oIF_Ins, oMC_En, oMC_Addr
  );

endinterface

// File: rtl/icache_mem.sv
// -----------------------------------------------------------------------------
// icache_mem
// Valid / tag / data storage for a direct-mapped, one-word-per-line cache.
//   clk, rst   : clock and synchronous active-high reset (clears valid bits)
//   rd_idx     : combinational read index
//   rd_valid, rd_tag, rd_data : contents of line rd_idx
//   wr_en, wr_idx, wr_tag, wr_data : synchronous line fill
// -----------------------------------------------------------------------------
module icache_mem
  import icache_pkg::*;
#(
  parameter  int IDX_W = ICACHE_IDX_W,
  localparam int TAG_W = REG_DAT_W - 2 - IDX_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [INS_DAT_W-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [INS_DAT_W-1:0] wr_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]     valid_r;
  logic [TAG_W-1:0]     tag_r  [LINES];
  logic [INS_DAT_W-1:0] data_r [LINES];

  assign rd_valid = valid_r[rd_idx];
  assign rd_tag   = tag_r[rd_idx];
  assign rd_data  = data_r[rd_idx];

  // Valid bits: all cleared on reset, set by a fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= {LINES{1'b0}};
    end else if (wr_en) begin
      valid_r[wr_idx] <= 1'b1;
    end
  end

  // Tag and data words: no reset needed; a fill coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      tag_r[wr_idx]  <= wr_tag;
      data_r[wr_idx] <= wr_data;
    end
  end

endmodule

// File: rtl/icache.sv
// -----------------------------------------------------------------------------
// icache
// Direct-mapped, one-word-per-line instruction cache. One fetch is serviced at
// a time: hits answer one cycle later, misses read the word from the memory
// controller, fill the line and answer. One request arriving during a fill is
// held pending; a ROB flush suppresses the in-flight response without
// cancelling the memory read.
//   clk, rst : clock, synchronous active-high reset
//   bus      : icache_if.slave (fetch, memory controller and flush signals)
// -----------------------------------------------------------------------------
module icache
  import icache_pkg::*;
#(
  parameter int IDX_W = ICACHE_IDX_W
) (
  input logic     clk,
  input logic     rst,
  icache_if.slave bus
);

  localparam int WORD_W = REG_DAT_W - 2;   // word address (byte offset dropped)
  localparam int TAG_W  = WORD_W - IDX_W;

  state_e               state_r, state_n_s;
  logic                 pend_v_r, pend_v_n_s;
  logic [WORD_W-1:0]    pend_pc_r, pend_pc_n_s;
  logic                 drop_r, drop_n_s;
  logic [WORD_W-1:0]    miss_word_r, miss_word_n_s;
  logic                 oif_en_r, oif_en_n_s;
  logic [INS_DAT_W-1:0] oif_ins_r, oif_ins_n_s;
  logic                 omc_en_r, omc_en_n_s;
  logic [REG_DAT_W-1:0] omc_addr_r, omc_addr_n_s;

  logic                 req_v_s;
  logic [WORD_W-1:0]    req_word_s;
  logic                 hit_s;
  logic                 rd_valid_s;
  logic [TAG_W-1:0]     rd_tag_s;
  logic [INS_DAT_W-1:0] rd_data_s;
  logic                 wr_en_s;
  logic                 pc_lsb_unused_s;

  // Byte offset of the fetch address carries no information for word fetches.
  assign pc_lsb_unused_s = ^bus.iIF_Pc[1:0];

  // Lookup source: a live strobe wins over (overwrites) the pending request.
  always_comb begin
    if (bus.iIF_En) begin
      req_word_s = bus.iIF_Pc[REG_DAT_W-1:2];
    end else begin
      req_word_s = pend_pc_r;
    end
    req_v_s = (bus.iIF_En | pend_v_r) & ~bus.iROB_Mp;
  end

  assign hit_s = rd_valid_s && (rd_tag_s == req_word_s[WORD_W-1:IDX_W]);

  icache_mem #(.IDX_W(IDX_W)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (req_word_s[IDX_W-1:0]),
    .rd_valid (rd_valid_s),
    .rd_tag   (rd_tag_s),
    .rd_data  (rd_data_s),
    .wr_en    (wr_en_s),
    .wr_idx   (miss_word_r[IDX_W-1:0]),
    .wr_tag   (miss_word_r[WORD_W-1:IDX_W]),
    .wr_data  (bus.iMC_Dat)
  );

  // Next-state and next-output logic of the IDLE/FILL controller.
  always_comb begin
    state_n_s     = state_r;
    pend_v_n_s    = pend_v_r;
    pend_pc_n_s   = pend_pc_r;
    drop_n_s      = drop_r;
    miss_word_n_s = miss_word_r;
    oif_en_n_s    = 1'b0;
    oif_ins_n_s   = oif_ins_r;
    omc_en_n_s    = omc_en_r;
    omc_addr_n_s  = omc_addr_r;
    wr_en_s       = 1'b0;

    case (state_r)
      IDLE: begin
        // Any pending request is consumed (or flushed) here.
        pend_v_n_s = 1'b0;
        drop_n_s   = 1'b0;
        if (req_v_s) begin
          if (hit_s) begin
            oif_en_n_s  = 1'b1;
            oif_ins_n_s = rd_data_s;
          end else begin
            miss_word_n_s = req_word_s;
            omc_en_n_s    = 1'b1;
            omc_addr_n_s  = {req_word_s, 2'b00};
            state_n_s     = FILL;
          end
        end else begin
          state_n_s = IDLE;
        end
      end

      FILL: begin
        // Flush kills the pending slot and the response, never the read.
        if (bus.iROB_Mp) begin
          drop_n_s   = 1'b1;
          pend_v_n_s = 1'b0;
        end else if (bus.iIF_En) begin
          pend_v_n_s  = 1'b1;
          pend_pc_n_s = bus.iIF_Pc[REG_DAT_W-1:2];
        end else begin
          pend_v_n_s = pend_v_r;
        end

        if (bus.iMC_En) begin
          wr_en_s    = 1'b1;
          omc_en_n_s = 1'b0;
          drop_n_s   = 1'b0;
          state_n_s  = IDLE;
          if (!drop_r && !bus.iROB_Mp) begin
            oif_en_n_s  = 1'b1;
            oif_ins_n_s = bus.iMC_Dat;
          end else begin
            oif_en_n_s = 1'b0;
          end
        end else begin
          state_n_s = FILL;
        end
      end

      default: begin
        state_n_s  = IDLE;
        omc_en_n_s = 1'b0;
      end
    endcase
  end

  // Controller state, miss/pending registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      pend_v_r    <= 1'b0;
      pend_pc_r   <= {WORD_W{1'b0}};
      drop_r      <= 1'b0;
      miss_word_r <= {WORD_W{1'b0}};
      oif_en_r    <= 1'b0;
      oif_ins_r   <= {INS_DAT_W{1'b0}};
      omc_en_r    <= 1'b0;
      omc_addr_r  <= {REG_DAT_W{1'b0}};
    end else begin
      state_r     <= state_n_s;
      pend_v_r    <= pend_v_n_s;
      pend_pc_r   <= pend_pc_n_s;
      drop_r      <= drop_n_s;
      miss_word_r <= miss_word_n_s;
      oif_en_r    <= oif_en_n_s;
      oif_ins_r   <= oif_ins_n_s;
      omc_en_r    <= omc_en_n_s;
      omc_addr_r  <= omc_addr_n_s;
    end
  end

  assign bus.oIF_En   = oif_en_r;
  assign bus.oIF_Ins  = oif_ins_r;
  assign bus.oMC_En   = omc_en_r;
  assign bus.oMC_Addr = omc_addr_r;

endmodule

// File: tb/tb_icache.sv
// -----------------------------------------------------------------------------
// tb_icache
// Scoreboard bench for icache. A reference model (map index -> cached word
// address) predicts hit/miss per request; expected responses and expected
// memory read addresses are queued at issue time and popped by an independent
// response monitor and a memory-controller responder.
// -----------------------------------------------------------------------------
module tb_icache;

  localparam int IDX_W = 8;

  typedef struct {
    logic [31:0] data;
    int          due;
    bit          exact;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  icache_if bus();

  icache #(.IDX_W(IDX_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          mem_lat = -1;      // <0: random 0..2 extra cycles
  bit          hold_check = 1'b1; // check oMC_En/oMC_Addr stability while waiting
  bit          mem_busy = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] mc_q[$];
  logic [31:0] model_line [int];  // index -> word address held in that line
  exp_t        mon_e;
  logic [31:0] rsp_addr;
  logic [31:0] rsp_exp;
  int          rsp_lat;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  function automatic int line_of(input logic [31:0] pc);
    return int'((pc >> 2) % (32'd1 << IDX_W));
  endfunction

  function automatic bit model_hit(input logic [31:0] pc);
    int idx = line_of(pc);
    return model_line.exists(idx) && (model_line[idx] == (pc >> 2));
  endfunction

  // Model a request in service order: misses install the line and expect a read.
  task automatic predict(input logic [31:0] pc, input bit respond, input bit exact);
    exp_t e;
    bit   h = model_hit(pc);
    if (!h) begin
      mc_q.push_back(pc & 32'hFFFF_FFFC);
      model_line[line_of(pc)] = pc >> 2;
    end
    if (respond) begin
      e.data  = mem_word(pc & 32'hFFFF_FFFC);
      e.exact = h && exact;
      e.due   = e.exact ? cyc + 1 : cyc + 40;
      exp_q.push_back(e);
    end
  endtask

  task automatic issue(input logic [31:0] pc, input bit respond, input bit exact);
    bus.iIF_En = 1'b1;
    bus.iIF_Pc = pc;
    predict(pc, respond, exact);
    @(negedge clk);
    bus.iIF_En = 1'b0;
    bus.iIF_Pc = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || mem_busy || bus.oMC_En === 1'b1) && n < 200);
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=busy expected=idle (pending responses %0d)", exp_q.size());
    end
  endtask

  // Response monitor: every oIF_En pulse must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.oIF_En === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=%h expected=no_response", bus.oIF_Ins);
        end else begin
          mon_e = exp_q.pop_front();
          check("resp_data", bus.oIF_Ins, mon_e.data);
          if (mon_e.exact) check("hit_latency", 32'(cyc), 32'(mon_e.due));
          else check("resp_deadline", {31'd0, cyc <= mon_e.due}, 32'd1);
        end
      end
    end
  end

  // Memory controller model: answers each read after a short latency.
  initial begin
    bus.iMC_En  = 1'b0;
    bus.iMC_Dat = 32'h0;
    forever begin
      @(negedge clk);
      if (bus.oMC_En === 1'b1) begin
        mem_busy = 1'b1;
        rsp_addr = bus.oMC_Addr;
        if (mc_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mc_read actual=%h expected=no_read", rsp_addr);
        end else begin
          rsp_exp = mc_q.pop_front();
          check("mc_addr", rsp_addr, rsp_exp);
        end
        rsp_lat = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 2));
        for (int i = 0; i < rsp_lat; i++) begin
          @(negedge clk);
          if (hold_check) check("mc_hold", {bus.oMC_En, bus.oMC_Addr[30:0]}, {1'b1, rsp_addr[30:0]});
        end
        bus.iMC_En  = 1'b1;
        bus.iMC_Dat = mem_word(rsp_addr);
        @(negedge clk);
        check("mc_drop", {31'd0, bus.oMC_En}, 32'd0);
        bus.iMC_En  = 1'b0;
        bus.iMC_Dat = $urandom;
        mem_busy    = 1'b0;
      end
    end
  end

  // Global time bound.
  initial begin
    #500000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pc;
    logic [31:0] pc2;
    rst         = 1'b1;
    bus.iIF_En  = 1'b0;
    bus.iIF_Pc  = 32'h0;
    bus.iROB_Mp = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_oIF_En",   {31'd0, bus.oIF_En}, 32'd0);
    check("rst_oMC_En",   {31'd0, bus.oMC_En}, 32'd0);
    check("rst_oIF_Ins",  bus.oIF_Ins,  32'd0);
    check("rst_oMC_Addr", bus.oMC_Addr, 32'd0);

    // Cold miss, then hit on the same address.
    issue(32'h0000_1000, 1'b1, 1'b1);
    check("miss_mc_en",   {31'd0, bus.oMC_En}, 32'd1);
    check("miss_mc_addr", bus.oMC_Addr, 32'h0000_1000);
    wait_idle();
    issue(32'h0000_1000, 1'b1, 1'b1);
    check("hit_no_mc", {31'd0, bus.oMC_En}, 32'd0);
    wait_idle();

    // Conflict eviction on index 0 (byte offset bits must be ignored).
    issue(32'h0000_2000, 1'b1, 1'b1);
    wait_idle();
    issue(32'h0000_1002, 1'b1, 1'b1);
    wait_idle();

    // Request during a fill is held pending and answered in order.
    issue(32'h0000_2000, 1'b1, 1'b1);
    wait_idle();
    issue(32'h0000_1000, 1'b1, 1'b1);
    issue(32'h0000_1004, 1'b1, 1'b0);
    wait_idle();

    // Flush during a fill: line still written, no response; later request pends.
    mem_lat = 3;
    issue(32'h0000_1010, 1'b0, 1'b0);
    bus.iROB_Mp = 1'b1;
    @(negedge clk);
    bus.iROB_Mp = 1'b0;
    @(negedge clk);
    issue(32'h0000_3000, 1'b1, 1'b0);
    wait_idle();
    mem_lat = -1;
    issue(32'h0000_1010, 1'b1, 1'b1);
    wait_idle();

    // Flush on the same edge as a request in IDLE discards it.
    bus.iROB_Mp = 1'b1;
    bus.iIF_En  = 1'b1;
    bus.iIF_Pc  = 32'h0000_1010;
    @(negedge clk);
    bus.iROB_Mp = 1'b0;
    bus.iIF_En  = 1'b0;
    wait_idle();

    // Reset mid-fill: the late memory answer must neither respond nor write.
    mem_lat    = 3;
    hold_check = 1'b0;
    issue(32'h0000_5000, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_line.delete();
    check("midfill_rst_mc_en", {31'd0, bus.oMC_En}, 32'd0);
    check("midfill_rst_if_en", {31'd0, bus.oIF_En}, 32'd0);
    wait_idle();
    mem_lat    = -1;
    hold_check = 1'b1;
    issue(32'h0000_5000, 1'b1, 1'b1);
    wait_idle();
    check("after_rst_refetch", 32'(mc_q.size()), 32'd0);

    // Warm eight lines, then eight back-to-back hits.
    for (int i = 0; i < 8; i++) begin
      issue(32'h0000_0200 + 32'(i * 4), 1'b1, 1'b1);
      wait_idle();
    end
    for (int i = 0; i < 8; i++) issue(32'h0000_0200 + 32'(i * 4), 1'b1, 1'b1);
    wait_idle();

    // Random traffic over a small conflicting address set.
    for (int it = 0; it < 300; it++) begin
      pc = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
      if (model_hit(pc)) begin
        issue(pc, 1'b1, 1'b1);
      end else begin
        issue(pc, 1'b1, 1'b1);
        if ($urandom_range(0, 1) == 1) begin
          pc2 = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2);
          issue(pc2, 1'b1, 1'b0);
        end
        wait_idle();
      end
    end
    wait_idle();

    check("end_mc_q_empty",  32'(mc_q.size()),  32'd0);
    check("end_exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the instruction fetch stage and the memory controller.
- Serves one fetch request at a time: 1-cycle response on a hit; on a miss, issues a word read to the memory controller, fills the line and then responds.
- Handles ROB misprediction flushes without corrupting an in-flight memory read, and holds one request that arrives while a fill is draining.

## Interface
Parameters:
- IDX_W, default 8: index width; 2^IDX_W lines of one 32-bit word each.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- iIF_En  in  1  fetch request strobe (one-cycle pulse).
- iIF_Pc  in  `REG_DAT_W  fetch address; bits [1:0] ignored.
- oIF_En  out  1  response strobe (one-cycle pulse).
- oIF_Ins  out  `INS_DAT_W  instruction; valid only while oIF_En=1.
- oMC_En  out  1  memory read request, held until acknowledged.
- oMC_Addr  out  `REG_DAT_W  word-aligned read address; bits [1:0] always 0.
- iMC_En  in  1  memory read done (one-cycle pulse).
- iMC_Dat  in  `INS_DAT_W  read data, valid with iMC_En.
- iROB_Mp  in  1  misprediction flush.

## Operation
Address split:
- index = PC[IDX_W+1:2]
- tag = PC[31:IDX_W+2]
- Per line: valid bit, tag, data word.

States:
- IDLE:
  - A request (iIF_En=1, or the pending request valid) is looked up.
  - Hit: load oIF_Ins with the data word, pulse oIF_En; stay in IDLE.
  - Miss: latch the address into the miss register, set oMC_En=1, set oMC_Addr={PC[31:2],2'b00}; go to FILL.
- FILL:
  - oMC_En stays high and oMC_Addr stays stable until iMC_En is sampled.
  - On iMC_En: write valid=1, the tag and iMC_Dat into the line; drop oMC_En.
  - If not dropped: pulse oIF_En with oIF_Ins=iMC_Dat.
  - Return to IDLE.

Pending request:
- One entry: pend_v plus pend_pc.
- iIF_En sampled in FILL captures pend_pc and sets pend_v.
- The pending request is serviced in IDLE the cycle after the fill completes.
- iIF_En while pend_v=1 is a protocol violation; the newer request overwrites the pending one.

Flush (iROB_Mp=1 at an edge):
- oIF_En <= 0.
- pend_v <= 0.
- A request sampled at the same edge is discarded.
- In FILL: the memory read is not cancelled; set drop=1. The fill still writes the line, but no response is given.
- drop clears on leaving FILL.
- A new request arriving after the flush but before the fill completes becomes pending and is serviced normally.

Reset:
- All valid bits, pend_v and drop cleared; state returns to IDLE.
- oIF_En=0, oMC_En=0, oIF_Ins=0, oMC_Addr=0.
- Reset mid-fill abandons the fill. A late iMC_En arriving in IDLE is ignored and writes nothing.

Other rules:
- iMC_En in IDLE is ignored.
- Tag compare is full-width.
- No replacement policy: a conflict overwrites the line.

## Timing
- Hit: request sampled at edge T -> oIF_En high during cycle T+1 only.
- Miss: request sampled at edge T -> oMC_En high from cycle T+1.
- iMC_En sampled at edge M:
  - line written at edge M;
  - oIF_En high during cycle M+1;
  - oMC_En low from cycle M+1.
- Pending request whose fill completes at edge M: looked up at edge M+1; a hit responds in cycle M+2.
- Minimum miss penalty, memory answering one cycle after the request: 2 cycles beyond a hit.
- oIF_En and oMC_En are registered outputs.
- Back-to-back hits: one request per cycle is accepted.

## Structure
- header.vh gains `ICACHE_IDX_W (default 8) and the state encodings (IDLE=0, FILL=1).
- `REG_DAT_W and `INS_DAT_W are reused from header.vh.
- Sub-module icache_mem holds the valid/tag/data arrays:
  - one combinational read port by index;
  - one synchronous write port;
  - synchronous valid clear on rst.
- icache holds the FSM, the miss/pending registers and the output registers.

## Test plan
- Reset, then request PC=0x0000_1000 -> oMC_En=1 with oMC_Addr=0x1000 next cycle. Memory returns 0x0000_0013 -> oIF_En pulses with oIF_Ins=0x13. A repeat request for 0x1000 -> hit, oIF_En the next cycle, no oMC_En.
- IDX_W=8: fill 0x1000, then request 0x2000 (same index, different tag) -> miss. Re-request 0x1000 -> miss again (conflict eviction).
- Request during FILL for 0x1004 -> held pending. After the 0x1000 fill responds, 0x1004 is looked up next cycle and misses -> second oMC_En, and the responses arrive in order.
- iROB_Mp during FILL for 0x1000, then a request for 0x3000 two cycles later -> no response for 0x1000. 0x3000 is serviced after the fill completes. A later request for 0x1000 hits.
- rst mid-fill, then iMC_En pulses -> no oIF_En, no write. A request for the same address afterwards misses.
- Hit requests on 8 consecutive cycles after warm-up -> 8 consecutive oIF_En pulses with the correct words.
